dp_datapath: RTL and testbench

DP_DATAPATH -- requirements
Module: dp_datapath

---
 rtl/dp_datapath.sv | 163 ++++++++++++++++
 tb/tb_dp_datapath.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_datapath.sv
// ---------------------------------------------------------------------------
// dp_datapath -- 4-bit register-file / ALU datapath
//
// Purpose
//   A four-entry, 4-bit register file with two read ports. The ports feed a
//   small ALU (add, sub, and, xor). The ALU result can be written back to the
//   register file and is also registered onto 'out'. All state changes on the
//   rising edge of clk. Reset is synchronous and active-high.
//
// Ports
//   clk  in   1  single clock, rising edge
//   rst  in   1  synchronous active-high reset (clears out and r0..r3)
//   in1  in   4  external operand A (write-mux source 11)
//   in2  in   4  external operand B (write-mux source 10)
//   s1   in   2  write-data select: 00 zero, 01 ALU, 10 in2, 11 in1
//   wa   in   2  write address
//   we   in   1  write enable
//   raa  in   2  read address, port A
//   rea  in   1  read enable, port A (disabled port reads 4'h0)
//   rab  in   2  read address, port B
//   reb  in   1  read enable, port B (disabled port reads 4'h0)
//   c    in   2  ALU op: 00 add, 01 sub, 10 and, 11 xor
//   s2   in   1  output select: 0 forces zero, 1 passes ALU result
//   out  out  4  registered datapath result
//
// Configuration
//   DP_BYPASS_EN  When defined, a read port whose address matches wa during an
//                 enabled write returns the value being written in the same
//                 cycle (write-through). Without it, the read port returns the
//                 stored, pre-write value.
// ---------------------------------------------------------------------------
module dp_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [1:0] s1,
  input  logic [1:0] wa,
  input  logic       we,
  input  logic [1:0] raa,
  input  logic       rea,
  input  logic [1:0] rab,
  input  logic       reb,
  input  logic [1:0] c,
  input  logic       s2,
  output logic [3:0] out
);

  // Write-data mux encodings
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_IN2  = 2'b10;
  localparam logic [1:0] SEL_IN1  = 2'b11;

  // ALU op encodings
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  logic [3:0] regs [4];
  logic [3:0] wd_ext;   // write data from the non-ALU sources
  logic [3:0] wd;       // final write data
  logic [3:0] a_data;
  logic [3:0] b_data;
  logic [3:0] alu_y;

  // -------------------------------------------------------------------------
  // Write-data mux. It is split so the ALU-independent part (wd_ext) can be
  // forwarded to the read ports without creating a path from the ALU output
  // back to its own inputs.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wd_ext = 4'h0;
    case (s1)
      SEL_IN2: wd_ext = in2;
      SEL_IN1: wd_ext = in1;
      default: wd_ext = 4'h0;
    endcase
  end

  assign wd = (s1 == SEL_ALU) ? alu_y : wd_ext;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
`ifdef DP_BYPASS_EN
  // Write-through is limited to the external/zero sources. Forwarding the
  // ALU result would let the ALU feed its own operands within a single cycle,
  // which is a combinational loop. When s1 selects the ALU, the read ports
  // therefore return the stored value.
  logic byp_ok;
  assign byp_ok = we && (s1 != SEL_ALU);

  always_comb begin
    a_data = 4'h0;
    if (rea) begin
      a_data = (byp_ok && (raa == wa)) ? wd_ext : regs[raa];
    end
  end

  always_comb begin
    b_data = 4'h0;
    if (reb) begin
      b_data = (byp_ok && (rab == wa)) ? wd_ext : regs[rab];
    end
  end
`else
  // Reads see the value stored before this edge's write.
  always_comb begin
    a_data = 4'h0;
    if (rea) a_data = regs[raa];
  end

  always_comb begin
    b_data = 4'h0;
    if (reb) b_data = regs[rab];
  end
`endif

  // -------------------------------------------------------------------------
  // ALU: 4-bit results that wrap modulo 16. There is no carry or borrow
  // output.
  // -------------------------------------------------------------------------
  always_comb begin
    alu_y = 4'h0;
    case (c)
      OP_ADD: alu_y = a_data + b_data;
      OP_SUB: alu_y = a_data - b_data;
      OP_AND: alu_y = a_data & b_data;
      OP_XOR: alu_y = a_data ^ b_data;
      default: alu_y = 4'h0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Register file. Reset has priority over a write in the same cycle.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values, independent of block ordering.
  // NOTE: the register file is reset explicitly. Its four entries are plain
  // flops rather than a RAM macro, and a defined state is required after
  // reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'h0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // -------------------------------------------------------------------------
  // Output register: one cycle of latency from any input change.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)     out <= 4'h0;
    else if (s2) out <= alu_y;
    else         out <= 4'h0;
  end

endmodule

// File: tb/tb_dp_datapath.sv
// ---------------------------------------------------------------------------
// tb_dp_datapath -- self-checking bench for dp_datapath
//
// A vector table covers reset, load/ALU, wrap, gating and mid-operation
// reset. Hand-written sequences cover ALU feedback and same-cycle
// read-during-write. A final loop sweeps in1/in2 over 0..7 for all four ops.
// Expected values go into a scoreboard queue when a cycle is driven. They
// are popped and compared #1 after the clock edge that registers out.
// ---------------------------------------------------------------------------
module tb_dp_datapath;

`ifdef DP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in1, in2;
  logic [1:0] s1, wa, raa, rab, c;
  logic       we, rea, reb, s2;
  logic [3:0] out;

  always #5 clk = ~clk;

  dp_datapath dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .s1(s1), .wa(wa), .we(we),
    .raa(raa), .rea(rea), .rab(rab), .reb(reb), .c(c), .s2(s2), .out(out)
  );

  typedef struct {
    logic       rst;
    logic [1:0] s1;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       s2;
    logic [3:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic [1:0] s1_v,
                              input logic [3:0] i1, input logic [3:0] i2,
                              input logic [1:0] wa_v, input logic we_v,
                              input logic [1:0] ra, input logic rea_v,
                              input logic [1:0] rb, input logic reb_v,
                              input logic [1:0] c_v, input logic s2_v,
                              input logic [3:0] e, input string n);
    vec_t v;
    v.rst = r;   v.s1 = s1_v; v.in1 = i1;  v.in2 = i2;
    v.wa = wa_v; v.we = we_v; v.raa = ra;  v.rea = rea_v;
    v.rab = rb;  v.reb = reb_v; v.c = c_v; v.s2 = s2_v;
    v.exp = e;   v.name = n;
    return v;
  endfunction

  function automatic logic [3:0] golden(input logic [1:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] wide;
    case (op)
      2'b00:   wide = {1'b0, a} + {1'b0, b};
      2'b01:   wide = {1'b0, a} - {1'b0, b};
      2'b10:   wide = {1'b0, a & b};
      default: wide = {1'b0, a ^ b};
    endcase
    return wide[3:0];
  endfunction

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; s1 = v.s1; in1 = v.in1; in2 = v.in2; wa = v.wa; we = v.we;
    raa = v.raa; rea = v.rea; rab = v.rab; reb = v.reb; c = v.c; s2 = v.s2;
  endtask

  // Push the expectation, clock once, then pop and compare away from the edge.
  task automatic clock_and_check(input string name, input logic [3:0] exp);
    sb_t e;
    sb_q.push_back('{exp, name});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.name, out, e.exp);
  endtask

  task automatic idle();
    rst = 1'b0; s1 = 2'b00; in1 = 4'h0; in2 = 4'h0; wa = 2'd0; we = 1'b0;
    raa = 2'd0; rea = 1'b0; rab = 2'd0; reb = 1'b0; c = 2'b00; s2 = 1'b0;
  endtask

  // Load a register from in1 with the output gated, so out must read 0.
  task automatic write_reg(input logic [1:0] addr, input logic [3:0] val);
    idle();
    s1 = 2'b11; in1 = val; wa = addr; we = 1'b1;
    clock_and_check("write_gated", 4'h0);
  endtask

  task automatic read_op(input logic [1:0] op, input logic [3:0] exp,
                         input string name);
    idle();
    raa = 2'd1; rea = 1'b1; rab = 2'd2; reb = 1'b1; c = op; s2 = 1'b1;
    clock_and_check(name, exp);
  endtask

  initial begin
    // ---------------- vector table --------------------------------------
    //                rst s1    in1   in2   wa we raa rea rab reb c    s2 exp
    vecs.push_back(mk(1, 2'b00, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'h0, "reset"));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, i[1:0], 1, i[1:0], 1, 2'b00, 1, 4'h0, "post_reset_rd"));
    vecs.push_back(mk(0, 2'b11, 4'h6, 4'h0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 4'h0, "load_r1"));
    vecs.push_back(mk(0, 2'b10, 4'h0, 4'h3, 2, 1, 0, 0, 0, 0, 2'b00, 0, 4'h0, "load_r2"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b00, 1, 4'h9, "add_6_3"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b01, 1, 4'h3, "sub_6_3"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b10, 1, 4'h2, "and_6_3"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b11, 1, 4'h5, "xor_6_3"));
    vecs.push_back(mk(0, 2'b11, 4'h2, 4'h0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 4'h0, "load_r1_2"));
    // r2 is written with 5 while being read: the old value 3 is seen unless
    // write-through is built in.
    vecs.push_back(mk(0, 2'b10, 4'h0, 4'h5, 2, 1, 1, 1, 2, 1, 2'b00, 1,
                      BYPASS ? 4'h7 : 4'h5, "rd_during_wr"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b01, 1, 4'hD, "sub_wrap_2_5"));
    vecs.push_back(mk(0, 2'b11, 4'h9, 4'h0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 4'h0, "load_r1_9"));
    vecs.push_back(mk(0, 2'b10, 4'h0, 4'h8, 2, 1, 0, 0, 0, 0, 2'b00, 0, 4'h0, "load_r2_8"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b00, 1, 4'h1, "add_wrap_9_8"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 1, 2'b11, 0, 4'h0, "s2_gate"));
    vecs.push_back(mk(0, 2'b10, 4'h0, 4'h7, 2, 1, 0, 0, 0, 0, 2'b00, 0, 4'h0, "load_r2_7"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 0, 2, 1, 2'b00, 1, 4'h7, "rea_off"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 2, 0, 2'b00, 1, 4'h9, "reb_off"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 0, 2, 0, 2'b11, 1, 4'h0, "both_off"));
    vecs.push_back(mk(1, 2'b11, 4'hF, 4'h0, 0, 1, 1, 1, 2, 1, 2'b00, 1, 4'h0, "reset_mid_op"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 4'h0, "wr_discarded"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 1, 1, 0, 0, 2'b00, 1, 4'h0, "r1_cleared"));
    vecs.push_back(mk(0, 2'b11, 4'h5, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'h0, "we_off"));
    vecs.push_back(mk(0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 4'h0, "we_off_hold"));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      clock_and_check(vecs[i].name, vecs[i].exp);
    end

    // ---------------- ALU feedback and read-during-write -----------------
    write_reg(2'd1, 4'h3);
    write_reg(2'd2, 4'h4);
    idle();
    raa = 2'd1; rea = 1'b1; rab = 2'd2; reb = 1'b1; c = 2'b00;
    s1 = 2'b01; wa = 2'd3; we = 1'b1; s2 = 1'b1;
    clock_and_check("fb_sum", 4'h7);
    idle();
    raa = 2'd3; rea = 1'b1; c = 2'b00; s2 = 1'b1;
    clock_and_check("fb_r3", 4'h7);

    // r3 <= r3 + r2 through the ALU path. Port A must see the stored 7.
    idle();
    raa = 2'd3; rea = 1'b1; rab = 2'd2; reb = 1'b1; c = 2'b00;
    s1 = 2'b01; wa = 2'd3; we = 1'b1; s2 = 1'b1;
    clock_and_check("fb_self", 4'hB);
    idle();
    raa = 2'd3; rea = 1'b1; s2 = 1'b1;
    clock_and_check("fb_self_r3", 4'hB);

    // Same-cycle read on port A while r3 is loaded from in1.
    idle();
    s1 = 2'b11; in1 = 4'h2; wa = 2'd3; we = 1'b1;
    raa = 2'd3; rea = 1'b1; c = 2'b00; s2 = 1'b1;
    clock_and_check("same_cycle_rd_a", BYPASS ? 4'h2 : 4'hB);

    // Same-cycle read on port B while r0 is loaded from in2.
    idle();
    s1 = 2'b10; in2 = 4'h5; wa = 2'd0; we = 1'b1;
    rab = 2'd0; reb = 1'b1; c = 2'b00; s2 = 1'b1;
    clock_and_check("same_cycle_rd_b", BYPASS ? 4'h5 : 4'h0);
    idle();
    rab = 2'd0; reb = 1'b1; c = 2'b00; s2 = 1'b1;
    clock_and_check("r0_after_wr", 4'h5);

    // ---------------- sweep in1,in2 over 0..7, all ops ------------------
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        write_reg(2'd1, a[3:0]);
        write_reg(2'd2, b[3:0]);
        for (int op = 0; op < 4; op++)
          read_op(op[1:0], golden(op[1:0], a[3:0], b[3:0]), "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
